// File: rtl/regfile_wb_arbiter.sv
// Purpose : shares the single register-file write port among NUM_REQ write-back sources, round-robin.
// Latency : 1 cycle from a transfer (valid & ready on a rising edge) to the registered rf_* outputs.
// Backpres: at most one req_ready_o bit per cycle; none while stall_i or rst_i is high.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   stall_i               pipeline stall, suppresses every grant
//   req_valid_i/addr/data per-requester write request (0=ALU, 1=LSU, 2=MUL)
//   req_ready_o           per-requester grant, one-hot or zero
//   rf_we_o/waddr/wdata   registered register-file write port
//   grant_id_o            index of the requester whose write is presented this cycle

package riscv_cpu_pkg;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
endpackage

module regfile_wb_arbiter
    import riscv_cpu_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 stall_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    output logic                                 rf_we_o,
    output logic [ADDR_WIDTH-1:0]                rf_waddr_o,
    output logic [DATA_WIDTH-1:0]                rf_wdata_o,
    output logic [ID_W-1:0]                      grant_id_o
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] sel_idx;
    logic            sel_vld;
    logic            xfer;

    // Scan offsets from farthest to nearest so the requester closest to rr_ptr
    // overwrites any earlier candidate; no early-exit flag is needed.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid_i[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Grant is a function of valid, stall and rr_ptr only; address/data never
    // influence it. Reset also masks it so nothing transfers while held.
    always_comb begin
        req_ready_o = '0;
        if (sel_vld && !stall_i && !rst_i) begin
            req_ready_o[sel_idx] = 1'b1;
        end
    end

    assign xfer = |req_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr     <= '0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            grant_id_o <= '0;
        end else begin
            rf_we_o <= 1'b0;
            if (xfer) begin
                // x0 writes are accepted (they consume a slot and advance the
                // pointer) but never raise the write enable.
                rf_we_o    <= (req_addr_i[sel_idx] != '0);
                rf_waddr_o <= req_addr_i[sel_idx];
                rf_wdata_o <= req_data_i[sel_idx];
                grant_id_o <= sel_idx;
                rr_ptr     <= (sel_idx == LAST_ID) ? '0 : sel_idx + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose : self-checking bench for regfile_wb_arbiter against a queue-free behavioural model.
// Latency : model expects registered outputs one edge after each grant.
// Backpres: requesters hold addr/data while valid and not granted.

module tb_regfile_wb_arbiter;
    import riscv_cpu_pkg::*;

    localparam int N  = 3;
    localparam int IW = $clog2(N);

    logic                             clk_i = 1'b0;
    logic                             rst_i = 1'b1;
    logic                             stall_i = 1'b0;
    logic [N-1:0]                     req_valid_i = '0;
    logic [N-1:0][ADDR_WIDTH-1:0]     req_addr_i = '0;
    logic [N-1:0][DATA_WIDTH-1:0]     req_data_i = '0;
    logic [N-1:0]                     req_ready_o;
    logic                             rf_we_o;
    logic [ADDR_WIDTH-1:0]            rf_waddr_o;
    logic [DATA_WIDTH-1:0]            rf_wdata_o;
    logic [IW-1:0]                    grant_id_o;

    always #5 clk_i = ~clk_i;

    regfile_wb_arbiter #(.NUM_REQ(N)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .grant_id_o  (grant_id_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: priority pointer and the expected write-port contents.
    int                      m_ptr;
    logic                    m_we;
    logic [ADDR_WIDTH-1:0]   m_waddr;
    logic [DATA_WIDTH-1:0]   m_wdata;
    int                      m_gid;
    int                      wait_cnt[N];
    int                      max_wait = 0;
    int                      last_grant = -1;
    logic [DATA_WIDTH-1:0]   tb_rf[32];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Round-robin rule: first valid requester starting at the pointer, wrapping.
    function automatic int pick();
        if (stall_i || rst_i) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_gid   = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        last_grant = -1;
    endtask

    task automatic set_req(input int i, input logic v, input int a, input logic [31:0] d);
        req_valid_i[i] = v;
        req_addr_i[i]  = ADDR_WIDTH'(a);
        req_data_i[i]  = d;
    endtask

    // Entered just after a falling edge with inputs applied; returns on the next falling edge.
    task automatic step();
        int           g;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] obs_rdy;
        #1;
        g = pick();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        obs_rdy = req_ready_o;
        check_eq("ready", obs_rdy, exp_rdy);
        check_eq("onehot0", $onehot0(obs_rdy), 1'b1);
        @(posedge clk_i);
        for (int i = 0; i < N; i++) begin
            if (req_valid_i[i] && !obs_rdy[i]) begin
                if (!stall_i) wait_cnt[i]++;
            end else begin
                wait_cnt[i] = 0;
            end
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
        if (g >= 0) begin
            m_we    = (req_addr_i[g] != '0);
            m_waddr = req_addr_i[g];
            m_wdata = req_data_i[g];
            m_gid   = g;
            m_ptr   = (g + 1) % N;
        end else begin
            m_we = 1'b0;
        end
        last_grant = g;
        #1;
        check_eq("rf_we",    rf_we_o,    m_we);
        check_eq("rf_waddr", rf_waddr_o, m_waddr);
        check_eq("rf_wdata", rf_wdata_o, m_wdata);
        check_eq("grant_id", grant_id_o, m_gid);
        if (rf_we_o) tb_rf[rf_waddr_o] = rf_wdata_o;
        @(negedge clk_i);
    endtask

    // Reset pulse between edges; outputs must clear without waiting for a clock.
    task automatic pulse_reset();
        rst_i = 1'b1;
        #1;
        check_eq("rst_we",    rf_we_o,     1'b0);
        check_eq("rst_ready", req_ready_o, '0);
        check_eq("rst_waddr", rf_waddr_o,  '0);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tb_rf[i] = '0;
        model_reset();

        // Held reset with all requesters valid: nothing granted, outputs zero.
        req_valid_i = '1;
        #2;
        check_eq("rst_ready", req_ready_o, '0);
        check_eq("rst_we",    rf_we_o,     1'b0);
        check_eq("rst_wdata", rf_wdata_o,  '0);
        check_eq("rst_gid",   grant_id_o,  '0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // All three valid: granted 0,1,2 in turn, writes (1,A),(2,B),(3,C).
        set_req(0, 1'b1, 1, 32'h0000_000A);
        set_req(1, 1'b1, 2, 32'h0000_000B);
        set_req(2, 1'b1, 3, 32'h0000_000C);
        repeat (3) step();
        req_valid_i = '0;
        step();
        check_eq("rf_x1", tb_rf[1], 32'h0000_000A);
        check_eq("rf_x2", tb_rf[2], 32'h0000_000B);
        check_eq("rf_x3", tb_rf[3], 32'h0000_000C);

        // x0 write from requester 1 is consumed, dropped, and advances the pointer to 2.
        pulse_reset();
        set_req(1, 1'b1, 0, 32'h0000_DEAD);
        step();
        req_valid_i = '0;
        step();
        req_valid_i = '1;
        step();
        req_valid_i = '0;
        step();

        // Stall with two pending requesters, then release: 0 first, then 1.
        pulse_reset();
        set_req(0, 1'b1, 4, 32'h1234_0000);
        set_req(1, 1'b1, 6, 32'h1234_0001);
        stall_i = 1'b1;
        repeat (3) step();
        stall_i = 1'b0;
        step();
        req_valid_i[0] = 1'b0;
        step();
        req_valid_i = '0;
        step();

        // Same destination from 0 and 2 with pointer at 2: 0x22 lands first, 0x11 last.
        pulse_reset();
        set_req(1, 1'b1, 7, 32'h0000_0077);
        step();
        req_valid_i = '0;
        set_req(0, 1'b1, 5, 32'h0000_0011);
        set_req(2, 1'b1, 5, 32'h0000_0022);
        step();
        req_valid_i[2] = 1'b0;
        step();
        req_valid_i = '0;
        step();
        check_eq("rf_x5", tb_rf[5], 32'h0000_0011);

        // Reset while a write is being presented; requester 0 leads afterwards.
        set_req(2, 1'b1, 9, 32'h0000_0099);
        step();
        pulse_reset();
        set_req(0, 1'b1, 10, 32'h0000_00A0);
        set_req(1, 1'b1, 11, 32'h0000_00B1);
        set_req(2, 1'b1, 12, 32'h0000_00C2);
        step();
        req_valid_i = '0;
        step();

        // Random traffic; requesters hold their request until granted.
        max_wait = 0;
        for (int c = 0; c < 10000; c++) begin
            stall_i = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid_i[i] || last_grant == i) begin
                    if ($urandom_range(0, 2) != 0) begin
                        set_req(i, 1'b1,
                                ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 31)),
                                $urandom);
                    end else begin
                        req_valid_i[i] = 1'b0;
                    end
                end
            end
            step();
        end
        check_eq("starve", (max_wait <= N - 1), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
